// File: rtl/e_mdu_pkg.sv
// Shared E-stage pipeline package: ALU op codes, MDU op encodings, MDU FSM
// state enum, default MDU latencies and a small op classification helper.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_NOP6  = 3'd6,
        MDU_NOP7  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;
    localparam int MDU_CNT_W           = 5;   // holds latencies up to 31

    // Multiply/divide ops occupy the unit for several cycles; MT ops do not.
    function automatic logic mdu_is_long(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational MDU arithmetic.
//   a, b            : latched rs / rt operands
//   op              : latched MDU op (MULT, MULTU, DIV, DIVU meaningful)
//   hi_next, lo_next: result to be written into HI/LO on completion
// Division truncates toward zero; remainder takes the dividend's sign.
// Divide by zero yields LO = all-ones, HI = dividend.
module e_mdu_arith
    import e_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mdu_op_e          op,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic              is_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  mag_a, mag_b, div_b, uq, ur, q, r;
    logic [WIDTH-1:0]  min_neg;

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign min_neg   = {1'b1, {(WIDTH-1){1'b0}}};

    // A 2W-bit product of sign/zero-extended operands, taken mod 2^2W,
    // is the exact signed/unsigned product.
    assign ext_a = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign ext_b = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign prod  = ext_a * ext_b;

    // Signed divide via magnitudes; the divisor is forced nonzero so the
    // unused quotient path never produces X in simulation.
    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;
    assign div_b = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign uq    = mag_a / div_b;
    assign ur    = mag_a % div_b;
    assign q     = (a_neg ^ b_neg) ? -uq : uq;
    assign r     = a_neg ? -ur : ur;

    always_comb begin
        hi_next = '0;
        lo_next = '0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                hi_next = prod[2*WIDTH-1:WIDTH];
                lo_next = prod[WIDTH-1:0];
            end
            MDU_DIV, MDU_DIVU: begin
                if (b == '0) begin
                    hi_next = a;
                    lo_next = '1;
                end else if ((op == MDU_DIV) && (a == min_neg) && (b == '1)) begin
                    hi_next = '0;
                    lo_next = min_neg;
                end else begin
                    hi_next = r;
                    lo_next = q;
                end
            end
            default: begin
                hi_next = '0;
                lo_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: FSM, latency counter, operand latches and
// the architectural HI/LO registers. Arithmetic lives in e_mdu_arith.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start, op         : MDU instruction valid in E, and its op code
//   rs_data, rt_data  : forwarded operands
//   hi, lo            : architectural HI/LO
//   busy              : multiply/divide in flight
//   stall_req         : busy, or a multiply/divide being issued this cycle
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_req
);

    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, b_q, hi_next, lo_next;
    mdu_op_e              op_q, op_in;
    logic                 accept, done, mt_hi, mt_lo;

    assign op_in     = mdu_op_e'(op);
    assign busy      = (state_q == MDU_RUN);
    assign stall_req = busy | (start & mdu_is_long(op_in));

    // MT writes only take effect from IDLE; in RUN they are dropped.
    assign mt_hi = (state_q == MDU_IDLE) && start && (op_in == MDU_MTHI);
    assign mt_lo = (state_q == MDU_IDLE) && start && (op_in == MDU_MTLO);

    always_ff @(posedge clk) begin
        if (reset) state_q <= MDU_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start && mdu_is_long(op_in)) begin
                    accept  = 1'b1;
                    state_d = MDU_RUN;
                    cnt_d   = ((op_in == MDU_MULT) || (op_in == MDU_MULTU))
                              ? MDU_CNT_W'(MULT_CYCLES) : MDU_CNT_W'(DIV_CYCLES);
                end
            end
            MDU_RUN: begin
                // The edge that takes the counter to zero is the completion edge.
                if (cnt_q <= MDU_CNT_W'(1)) begin
                    done    = 1'b1;
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - MDU_CNT_W'(1);
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= MDU_MULT;
            hi    <= '0;
            lo    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                a_q  <= rs_data;
                b_q  <= rt_data;
                op_q <= op_in;
            end
            if (done) begin
                hi <= hi_next;
                lo <= lo_next;
            end else begin
                if (mt_hi) hi <= rs_data;
                if (mt_lo) lo <= rs_data;
            end
        end
    end

    e_mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .a       (a_q),
        .b       (b_q),
        .op      (op_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

endmodule
